// File: rtl/touch_spi_responder.sv
// -----------------------------------------------------------------------------
// touch_spi_responder
// SPI mode-0 slave that mimics a resistive touch-screen controller. The master
// clocks in a command byte that begins with a start bit. The block then returns
// a 16-bit frame {busy=0, D11..D0, 000} that holds the selected conversion
// source. All SPI pins are oversampled by the system clock.
//
// Ports
//   clk, reset_n            system clock, async active-low reset
//   spi_sclk/ss_n/mosi      SPI inputs from the master (asynchronous to clk)
//   spi_miso, spi_miso_oe   response bit and its drive enable
//   x_pos, y_pos, z1, z2    12-bit conversion sources, snapshotted per frame
//   pen_down                panel-touched level
//   penirq_n                registered active-low pen interrupt
//   cmd_valid, cmd_byte     one-clk strobe and last accepted command
// -----------------------------------------------------------------------------
module touch_spi_responder #(
   parameter int SYNC_STAGES  = 2,  // 2..3
   parameter int SCLK_MAX_DIV = 8   // min clk periods per sclk period
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        spi_sclk,
   input  logic        spi_ss_n,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        spi_miso_oe,
   input  logic [11:0] x_pos,
   input  logic [11:0] y_pos,
   input  logic [11:0] z1,
   input  logic [11:0] z2,
   input  logic        pen_down,
   output logic        penirq_n,
   output logic        cmd_valid,
   output logic [7:0]  cmd_byte
);

   // MISO only settles before the master samples it when a half sclk period
   // covers the synchronizer latency. This empty block records that
   // relationship. It places no hardware.
   if (SCLK_MAX_DIV < 2 * (SYNC_STAGES + 1)) begin : g_sclk_too_fast
   end

   typedef enum logic [1:0] {HUNT, CMD, RESP} state_t;

   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] ss_sync_q,   ss_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sclk_dly_q,  sclk_dly_d;

   state_t      state_q,      state_d;
   logic [3:0]  bit_cnt_q,    bit_cnt_d;
   logic [7:1]  cmd_shift_q,  cmd_shift_d;   // bit 0 arrives straight from mosi
   logic [15:0] resp_shift_q, resp_shift_d;
   logic        spi_miso_q,   spi_miso_d;
   logic        cmd_valid_q,  cmd_valid_d;
   logic [7:0]  cmd_byte_q,   cmd_byte_d;
   logic        irq_en_q,     irq_en_d;
   logic        penirq_n_q,   penirq_n_d;

   logic        sclk_s, ss_s, mosi_s, sclk_rise, sclk_fall;
   logic [7:0]  cmd_full;
   logic [11:0] src, src_masked;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign ss_s      = ss_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   // The delayed copy resets to 0, the same value as the sclk synchronizer.
   // Reset release therefore cannot produce a false edge.
   assign sclk_rise = sclk_s & ~sclk_dly_q;
   assign sclk_fall = ~sclk_s & sclk_dly_q;

   assign cmd_full  = {cmd_shift_q, mosi_s};

   always_comb begin
      src = 12'h000;
      case (cmd_full[6:4])
         3'b101:  src = x_pos;
         3'b001:  src = y_pos;
         3'b011:  src = z1;
         3'b100:  src = z2;
         default: src = 12'h000;
      endcase
      // 8-bit mode returns only D11..D4.
      src_masked = cmd_full[3] ? {src[11:4], 4'h0} : src;
   end

   always_comb begin
      sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      ss_sync_d    = {ss_sync_q[SYNC_STAGES-2:0],   spi_ss_n};
      mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_dly_d   = sclk_s;

      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      cmd_shift_d  = cmd_shift_q;
      resp_shift_d = resp_shift_q;
      spi_miso_d   = spi_miso_q;
      cmd_valid_d  = 1'b0;
      cmd_byte_d   = cmd_byte_q;
      irq_en_d     = irq_en_q;

      if (ss_s) begin
         state_d    = HUNT;
         bit_cnt_d  = 4'd0;
         spi_miso_d = 1'b0;
      end else begin
         case (state_q)
            HUNT: begin
               spi_miso_d = 1'b0;
               if (sclk_rise && mosi_s) begin
                  state_d     = CMD;
                  cmd_shift_d = 7'b100_0000;
                  bit_cnt_d   = 4'd1;
               end
            end
            CMD: begin
               if (sclk_rise) begin
                  if (bit_cnt_q == 4'd7) begin
                     state_d      = RESP;
                     bit_cnt_d    = 4'd0;
                     cmd_byte_d   = cmd_full;
                     cmd_valid_d  = 1'b1;
                     irq_en_d     = (cmd_full[1:0] == 2'b00);
                     resp_shift_d = {1'b0, src_masked, 3'b000};
                  end else begin
                     // Bit n (1..6) lands at position 7-n, which equals ~n over 3 bits.
                     cmd_shift_d[~bit_cnt_q[2:0]] = mosi_s;
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            RESP: begin
               if (sclk_fall) begin
                  spi_miso_d   = resp_shift_q[15];
                  resp_shift_d = {resp_shift_q[14:0], 1'b0};
               end
               if (sclk_rise) begin
                  if (bit_cnt_q == 4'd15) begin
                     state_d    = HUNT;
                     bit_cnt_d  = 4'd0;
                     spi_miso_d = 1'b0;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            default: begin
               state_d    = HUNT;
               bit_cnt_d  = 4'd0;
               spi_miso_d = 1'b0;
            end
         endcase
      end

      penirq_n_d = ~(pen_down & irq_en_q & (state_q != RESP));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_sync_q  <= '0;
         ss_sync_q    <= '1;
         mosi_sync_q  <= '0;
         sclk_dly_q   <= 1'b0;
         state_q      <= HUNT;
         bit_cnt_q    <= 4'd0;
         cmd_shift_q  <= '0;
         resp_shift_q <= '0;
         spi_miso_q   <= 1'b0;
         cmd_valid_q  <= 1'b0;
         cmd_byte_q   <= 8'h00;
         irq_en_q     <= 1'b1;
         penirq_n_q   <= 1'b1;
      end else begin
         sclk_sync_q  <= sclk_sync_d;
         ss_sync_q    <= ss_sync_d;
         mosi_sync_q  <= mosi_sync_d;
         sclk_dly_q   <= sclk_dly_d;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         cmd_shift_q  <= cmd_shift_d;
         resp_shift_q <= resp_shift_d;
         spi_miso_q   <= spi_miso_d;
         cmd_valid_q  <= cmd_valid_d;
         cmd_byte_q   <= cmd_byte_d;
         irq_en_q     <= irq_en_d;
         penirq_n_q   <= penirq_n_d;
      end
   end

   assign spi_miso    = spi_miso_q;
   assign spi_miso_oe = ~ss_s;
   assign penirq_n    = penirq_n_q;
   assign cmd_valid   = cmd_valid_q;
   assign cmd_byte    = cmd_byte_q;

endmodule

// File: doc/touch_spi_responder.md
TOUCH_SPI_RESPONDER -- requirements
Module: touch_spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on spi_sclk, spi_mosi and spi_ss_n, legal range 2..3.
REQ-002 SHALL have parameter SCLK_MAX_DIV, default 8: minimum clk periods per spi_sclk period, documentation only, not checked in RTL.
REQ-003 SHALL have port clk, input, 1: single system clock; all state on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port spi_sclk, input, 1: SPI clock from master, mode 0 (CPOL=0, CPHA=0).
REQ-006 SHALL have port spi_ss_n, input, 1: active-low chip select.
REQ-007 SHALL have port spi_mosi, input, 1: command bits from master.
REQ-008 SHALL have port spi_miso, output, 1: response bits to master.
REQ-009 SHALL have port spi_miso_oe, output, 1: MISO drive enable, equal to synchronized ~spi_ss_n.
REQ-010 SHALL have ports x_pos, y_pos, z1, z2, input, 12 each: conversion sources.
REQ-011 SHALL have port pen_down, input, 1: level, 1 = panel touched.
REQ-012 SHALL have port penirq_n, output, 1: active-low pen interrupt to master.
REQ-013 SHALL have ports cmd_valid (output, 1: one-clk pulse) and cmd_byte (output, 8: last accepted command).

Function
REQ-014 SHALL synchronize spi_sclk, spi_ss_n and spi_mosi through SYNC_STAGES flops; edge detection uses the synchronized spi_sclk and its one-clk-delayed copy.
REQ-015 SHALL implement states HUNT, CMD, RESP; synchronized spi_ss_n high forces HUNT in the next clk from any state and clears bit counters.
REQ-016 In HUNT, on each spi_sclk rising edge: mosi=0 -> stay; mosi=1 (start bit) -> CMD with cmd_shift[7]=1, bit count 1.
REQ-017 In CMD, SHALL shift mosi MSB-first on each rising edge; on the 8th bit, latch cmd_byte, pulse cmd_valid for exactly 1 clk, and go to RESP.
REQ-018 Command decode: A[2:0]=cmd[6:4], MODE=cmd[3] (1 = 8-bit), PD[1:0]=cmd[1:0]; cmd[2] is ignored.
REQ-019 At CMD->RESP, SHALL snapshot one source: A=101 -> x_pos; 001 -> y_pos; 011 -> z1; 100 -> z2; any other -> 12'h000. Later source changes do not affect the frame.
REQ-020 The response shift register SHALL be 16 bits: {1'b0 busy, D11..D0, 3'b000}; MODE=1 zeroes D3..D0.
REQ-021 In RESP, SHALL update spi_miso with the next register bit (MSB first) on each spi_sclk falling edge; the first falling edge after the 8th command rising edge presents the busy bit.
REQ-022 spi_miso SHALL change no later than SYNC_STAGES+1 clk after the pin-level spi_sclk falling edge.
REQ-023 In RESP, SHALL count rising edges; after the 16th, SHALL return to HUNT. MOSI is ignored in RESP; start bits are not overlapped.
REQ-024 Outside RESP, spi_miso SHALL be 0.
REQ-025 irq_en SHALL be set to (PD==2'b00) at each cmd_valid.
REQ-026 penirq_n SHALL be registered: 0 iff pen_down & irq_en & (state != RESP); otherwise 1.
REQ-027 When spi_ss_n rises mid-CMD, SHALL not update cmd_byte or irq_en; when it rises mid-RESP, the frame is abandoned; neither case pulses cmd_valid.

Reset
REQ-028 While reset_n=0: state=HUNT; counters=0; spi_miso=0; spi_miso_oe=0; cmd_valid=0; cmd_byte=8'h00; irq_en=1; penirq_n=1; synchronizer flops: sclk=0, ss_n=1, mosi=0.
REQ-029 The first spi_sclk edge SHALL be detected no earlier than SYNC_STAGES+1 clk after reset_n deasserts; no spurious edge is produced by reset release.

Verification
REQ-030 Test 1: x_pos=12'hA5C, ss_n low, send 8'hD0, then 16 clocks -> cmd_valid pulses once, cmd_byte=8'hD0, master samples 0,1010_0101_1100,000.
REQ-031 Test 2: y_pos=12'h3F1, send 8'h98 (8-bit mode) -> samples 0,0011_1111,0000_000.
REQ-032 Test 3: three leading zero bits, then 8'hB0 -> HUNT skips the zeros; z1 is returned; cmd_valid fires after the 11th rising edge.
REQ-033 Test 4: ss_n raised after 4 command bits, then a new frame with 8'h90 -> no cmd_valid for the aborted frame; the new frame returns y_pos.
REQ-034 Test 5: pen_down=1 with PD=00 -> penirq_n=0 outside RESP and 1 during RESP; after a command with PD=01, penirq_n stays 1.
REQ-035 Test 6: reset_n asserted mid-RESP -> all outputs take REQ-028 values in the same clk (asynchronous); after release, the next frame responds correctly.
